rc4_ctrl: RTL
=============

Name: rc4_ctrl

Overview:
- Session sequencer for the RC4 engine: drives the 2-bit phase code NS consumed by the key generator and the stream cipher core.
- Admits a start request and holds the key handshake while the key schedule runs.
- Gates and counts message bytes during encode/decode, then reports done or error.
- Sits between the host interface and key_gene / cipher core; one instance per RC4 engine.

Parameters:
- MSG_LEN_W, 16: width of the message byte count and of bytes_left.
- KG_TIMEOUT, 300: maximum cycles spent in KEY before an error is flagged (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle session request.
- abort  in  1  cancel the current session.
- msg_len  in  MSG_LEN_W  bytes to process; sampled when start is accepted.
- key_rvalid  in  1  host holds key_init stable and valid.
- key_rready  out  1  controller is consuming the key (high throughout KEY).
- kg_done  in  1  key schedule finished (key generator's data_rready).
- NS  out  2  phase code: 00 INIT, 01 KEY_GENE, 10 EN_DE_CODE; 11 is never driven.
- core_ready  in  1  cipher core can accept a byte.
- din_valid  in  1  host offers a message byte.
- din_ready  out  1  byte accepted when din_valid && din_ready.
- bytes_left  out  MSG_LEN_W  remaining byte count.
- busy  out  1  session in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- All outputs registered except din_ready, which is combinational: (state==CODE) && core_ready && bytes_left!=0.
- Reset (rst low, asynchronous): state=FLUSH, NS=10, key_rready=0, busy=0, done=0, err=0, bytes_left=0, timeout counter=0.
- FLUSH: NS=10 for exactly one cycle to clear the key generator's counters and state; always followed by IDLE.
- IDLE: NS=00, busy=0.
  - start accepted only when start && key_rvalid && !abort.
  - On accept: bytes_left<=msg_len, err<=0, go to KEY.
  - start with key_rvalid=0 is ignored; no error is raised.
- KEY: NS=01, key_rready=1, busy=1.
  - On the first cycle with kg_done=1, NS stays 01 for that cycle so the key table is latched.
  - Next state is CODE if bytes_left!=0, otherwise DONE.
  - If key_rvalid drops while in KEY: err<=1, go to FLUSH, no done pulse.
- CODE: NS=10, busy=1.
  - Each accepted byte decrements bytes_left by 1; no wrap below 0.
  - Handshake with bytes_left==1 goes to DONE on the same edge (bytes_left becomes 0).
  - core_ready low stalls: no decrement, no timeout.
- DONE: NS=00, done=1 for one cycle, busy=0, then IDLE.
- abort=1 in KEY or CODE: go to FLUSH on the next edge, no done, err unchanged, bytes_left frozen.
  - abort wins over a simultaneous kg_done or last-byte handshake.
  - abort in IDLE or DONE has no effect.
- start while busy is ignored.
- A msg_len change after acceptance has no effect.
- Latency: accepted start to NS=01 is 1 cycle. kg_done high to NS=10 (or done) is 2 edges. Last byte handshake to done pulse is 1 cycle.
- Reset asserted mid-session: immediate return to FLUSH with reset values.

Optional Feature:
- Macro RC4_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on KEY entry and increments each cycle in KEY.
  - When it reaches KG_TIMEOUT without kg_done: err<=1, go to FLUSH, no done.
  - kg_done on the same cycle the counter reaches KG_TIMEOUT wins; no error.
- Not defined: no counter; KEY waits indefinitely for kg_done, abort, or a key_rvalid drop.

Test Plan:
- Reset release -> NS=10 for 1 cycle, then 00; busy=0, err=0, done=0.
- key_rvalid=1, start with msg_len=4, kg_done after 258 cycles, core_ready=1, din_valid=1 -> NS 01 then 10; 4 bytes accepted; bytes_left 4,3,2,1,0; one done pulse; NS=00.
- msg_len=0 -> KEY, then DONE straight after kg_done; din_ready never high.
- abort in CODE with bytes_left=2, same cycle as a handshake -> FLUSH (NS=10 one cycle), bytes_left stays 2, no done, err=0.
- key_rvalid dropped 10 cycles into KEY -> err=1 sticky, FLUSH then IDLE; next accepted start clears err.
- RC4_CTRL_TIMEOUT_EN with KG_TIMEOUT=300 and kg_done held low -> err=1 after 300 KEY cycles, no done; without the macro, still in KEY at cycle 1000.

Source files
------------

// File: rtl/rc4_ctrl_if.sv
// Host/engine-side signal bundle for the RC4 session sequencer (rc4_ctrl).
// The master modport is the host/engine side. The slave modport is the controller.
interface rc4_ctrl_if #(
  parameter int MSG_LEN_W = 16
);
  logic                 start;
  logic                 abort;
  logic [MSG_LEN_W-1:0] msg_len;
  logic                 key_rvalid;
  logic                 key_rready;
  logic                 kg_done;
  logic [1:0]           NS;
  logic                 core_ready;
  logic                 din_valid;
  logic                 din_ready;
  logic [MSG_LEN_W-1:0] bytes_left;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, abort, msg_len, key_rvalid, kg_done, core_ready, din_valid,
    input  key_rready, NS, din_ready, bytes_left, busy, done, err
  );

  modport slave (
    input  start, abort, msg_len, key_rvalid, kg_done, core_ready, din_valid,
    output key_rready, NS, din_ready, bytes_left, busy, done, err
  );
endinterface

// File: rtl/rc4_ctrl.sv
// RC4 session sequencer: drives the NS phase code, gates message bytes and reports done/err.
// Optional KEY-phase watchdog enabled by defining RC4_CTRL_TIMEOUT_EN.
module rc4_ctrl #(
  parameter int MSG_LEN_W  = 16,
  parameter int KG_TIMEOUT = 300
) (
  input logic        clk,
  input logic        rst,
  rc4_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_FLUSH     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_KEY       = 3'd2,
    ST_KEY_LATCH = 3'd3,
    ST_CODE      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [1:0] NS_INIT = 2'b00;
  localparam logic [1:0] NS_KEY  = 2'b01;
  localparam logic [1:0] NS_CODE = 2'b10;

  localparam logic [MSG_LEN_W-1:0] LEN_ZERO = {MSG_LEN_W{1'b0}};
  localparam logic [MSG_LEN_W-1:0] LEN_ONE  = {{(MSG_LEN_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_s;
  logic [MSG_LEN_W-1:0] bytes_left_r;
  logic [MSG_LEN_W-1:0] bytes_left_s;
  logic                 err_r;
  logic                 err_s;
  logic [1:0]           ns_r;
  logic [1:0]           ns_s;
  logic                 key_rready_r;
  logic                 key_rready_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 done_r;
  logic                 done_s;
  logic                 len_zero_s;
  logic                 din_ready_s;
  logic                 handshake_s;
  logic                 timeout_s;

  assign len_zero_s  = (bytes_left_r == LEN_ZERO);
  assign din_ready_s = (state_r == ST_CODE) && bus.core_ready && !len_zero_s;
  assign handshake_s = bus.din_valid && din_ready_s;

`ifdef RC4_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(KG_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_r;
  logic [TO_W-1:0] to_cnt_s;

  // The counter holds (KEY cycles elapsed - 1), so hitting KG_TIMEOUT-1 ends the KG_TIMEOUT-th cycle
  assign timeout_s = (to_cnt_r == TO_W'(KG_TIMEOUT - 1));

  // Watchdog next value: clear on KEY entry, count while in KEY
  always_comb begin
    to_cnt_s = to_cnt_r;
    if ((state_r == ST_IDLE) && (state_s == ST_KEY)) begin
      to_cnt_s = {TO_W{1'b0}};
    end else if (state_r == ST_KEY) begin
      to_cnt_s = to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_s = to_cnt_r;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_s;
    end
  end
`else
  logic kg_timeout_unused_s;
  assign kg_timeout_unused_s = (KG_TIMEOUT != 0);
  assign timeout_s           = 1'b0;
`endif

  // Next-state, byte count and sticky error
  always_comb begin
    state_s      = state_r;
    bytes_left_s = bytes_left_r;
    err_s        = err_r;
    case (state_r)
      ST_FLUSH: begin
        state_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.start && bus.key_rvalid && !bus.abort) begin
          state_s      = ST_KEY;
          bytes_left_s = bus.msg_len;
          err_s        = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_KEY: begin
        if (bus.abort) begin
          state_s = ST_FLUSH;
        end else if (!bus.key_rvalid) begin
          state_s = ST_FLUSH;
          err_s   = 1'b1;
        end else if (bus.kg_done) begin
          state_s = ST_KEY_LATCH;
        end else if (timeout_s) begin
          state_s = ST_FLUSH;
          err_s   = 1'b1;
        end else begin
          state_s = ST_KEY;
        end
      end
      // One extra KEY_GENE cycle lets the generator latch its table
      ST_KEY_LATCH: begin
        if (bus.abort) begin
          state_s = ST_FLUSH;
        end else if (!bus.key_rvalid) begin
          state_s = ST_FLUSH;
          err_s   = 1'b1;
        end else if (len_zero_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CODE;
        end
      end
      ST_CODE: begin
        if (bus.abort) begin
          state_s = ST_FLUSH;
        end else if (len_zero_s) begin
          state_s = ST_DONE;
        end else if (handshake_s) begin
          bytes_left_s = bytes_left_r - LEN_ONE;
          if (bytes_left_r == LEN_ONE) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CODE;
          end
        end else begin
          state_s = ST_CODE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_FLUSH;
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state register
  always_comb begin
    ns_s         = NS_INIT;
    key_rready_s = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    case (state_s)
      ST_FLUSH: begin
        ns_s = NS_CODE;
      end
      ST_IDLE: begin
        ns_s = NS_INIT;
      end
      ST_KEY, ST_KEY_LATCH: begin
        ns_s         = NS_KEY;
        key_rready_s = 1'b1;
        busy_s       = 1'b1;
      end
      ST_CODE: begin
        ns_s   = NS_CODE;
        busy_s = 1'b1;
      end
      ST_DONE: begin
        ns_s   = NS_INIT;
        done_s = 1'b1;
      end
      default: begin
        ns_s = NS_CODE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_FLUSH;
      bytes_left_r <= LEN_ZERO;
      err_r        <= 1'b0;
      ns_r         <= NS_CODE;
      key_rready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      bytes_left_r <= bytes_left_s;
      err_r        <= err_s;
      ns_r         <= ns_s;
      key_rready_r <= key_rready_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign bus.NS         = ns_r;
  assign bus.key_rready = key_rready_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.bytes_left = bytes_left_r;
  assign bus.din_ready  = din_ready_s;

endmodule
